iter_div: RTL and testbench

Iterative radix-2 restoring divider that answers the execute stage's divide requests over the same dividend/divisor/dout stream handshake. It accepts one 32-bit dividend/divisor pair, computes one quotient bit per cycle, and returns {quotient, remainder} with a one-cycle `m_axis_dout_tvalid` pulse. Two instances sit beside the HI/LO logic in the execute stage: one with SIGNED=1 for div, one with SIGNED=0 for divu.

---
 rtl/iter_div.sv | 123 ++++++++++++
 tb/tb_iter_div.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_div.sv
// Radix-2 restoring divider: one quotient bit per cycle, {quotient, remainder} strobed 32 cycles after accept.
// Both treadys stay low from accept until the strobe cycle has passed; the result has no backpressure.
module iter_div #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_flush,
    input  logic        s_axis_dividend_tvalid,
    output logic        s_axis_dividend_tready,
    input  logic [31:0] s_axis_dividend_tdata,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_divisor_tready,
    input  logic [31:0] s_axis_divisor_tdata,
    output logic        m_axis_dout_tvalid,
    output logic [63:0] m_axis_dout_tdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        rdy_q, rdy_d;
    logic [63:0] dout_q, dout_d;

    logic        accept;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] shifted;
    logic        q_bit;
    logic [31:0] rem_nx, quo_nx, q_fix, r_fix;

    assign accept = (state_q == IDLE) && rdy_q && s_axis_dividend_tvalid
                    && s_axis_divisor_tvalid && !div_flush;

    assign a_neg = SIGNED & s_axis_dividend_tdata[31];
    assign b_neg = SIGNED & s_axis_divisor_tdata[31];
    assign a_mag = a_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
    assign b_mag = b_neg ? -s_axis_divisor_tdata : s_axis_divisor_tdata;

    // quo_q starts as the dividend and is shifted out MSB-first while quotient bits shift in.
    assign shifted = {rem_q, quo_q[31]};
    assign q_bit   = (shifted >= {1'b0, dvs_q});
    assign rem_nx  = q_bit ? (shifted[31:0] - dvs_q) : shifted[31:0];
    assign quo_nx  = {quo_q[30:0], q_bit};
    assign q_fix   = qneg_q ? -quo_nx : quo_nx;
    assign r_fix   = rneg_q ? -rem_nx : rem_nx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (div_flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        dout_d  = {q_fix, r_fix};
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            rdy_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            rdy_q   <= rdy_d;
            dout_q  <= dout_d;
        end
    end

    assign s_axis_dividend_tready = rdy_q;
    assign s_axis_divisor_tready  = rdy_q;
    assign m_axis_dout_tvalid     = (state_q == DONE);
    assign m_axis_dout_tdata      = dout_q;

endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div: one signed and one unsigned instance share the request stream.
// Expected values are hand-computed constants.
module tb_iter_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        dvd_vld = 1'b0;
    logic        dvs_vld = 1'b0;
    logic [31:0] dvd_dat = '0;
    logic [31:0] dvs_dat = '0;
    logic        sel_s = 1'b0;

    logic        dvd_rdy_u, dvs_rdy_u, vld_u;
    logic        dvd_rdy_s, dvs_rdy_s, vld_s;
    logic [63:0] dat_u, dat_s;

    logic [1:0]  obs_rdy;
    logic        obs_vld;
    logic [63:0] obs_dat;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    iter_div #(.SIGNED(1'b0)) u_divu (
        .clk(clk), .reset(rst), .div_flush(flush),
        .s_axis_dividend_tvalid(dvd_vld), .s_axis_dividend_tready(dvd_rdy_u),
        .s_axis_dividend_tdata(dvd_dat),
        .s_axis_divisor_tvalid(dvs_vld), .s_axis_divisor_tready(dvs_rdy_u),
        .s_axis_divisor_tdata(dvs_dat),
        .m_axis_dout_tvalid(vld_u), .m_axis_dout_tdata(dat_u)
    );

    iter_div #(.SIGNED(1'b1)) u_divs (
        .clk(clk), .reset(rst), .div_flush(flush),
        .s_axis_dividend_tvalid(dvd_vld), .s_axis_dividend_tready(dvd_rdy_s),
        .s_axis_dividend_tdata(dvd_dat),
        .s_axis_divisor_tvalid(dvs_vld), .s_axis_divisor_tready(dvs_rdy_s),
        .s_axis_divisor_tdata(dvs_dat),
        .m_axis_dout_tvalid(vld_s), .m_axis_dout_tdata(dat_s)
    );

    assign obs_rdy = sel_s ? {dvd_rdy_s, dvs_rdy_s} : {dvd_rdy_u, dvs_rdy_u};
    assign obs_vld = sel_s ? vld_s : vld_u;
    assign obs_dat = sel_s ? dat_s : dat_u;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string tag);
        int strobes;
        int strobe_at;
        int rdy_hi;
        logic [63:0] got;
        sel_s = sgn;
        @(negedge clk);
        check({tag, "_rdy_pre"}, 64'(obs_rdy), 64'h3);
        dvd_dat = a;
        dvs_dat = b;
        dvd_vld = 1'b1;
        dvs_vld = 1'b1;
        @(posedge clk);
        #1;
        dvd_vld = 1'b0;
        dvs_vld = 1'b0;
        check({tag, "_rdy_e0"}, 64'(obs_rdy), 64'h0);
        strobes = 0;
        strobe_at = -1;
        rdy_hi = 0;
        got = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (obs_vld) begin
                strobes++;
                strobe_at = k;
                got = obs_dat;
            end
            if (k <= 32 && obs_rdy != 2'b00) rdy_hi++;
            if (k == 33) check({tag, "_rdy_e33"}, 64'(obs_rdy), 64'h3);
        end
        check({tag, "_rdy_busy"}, 64'(rdy_hi), 64'd0);
        check({tag, "_strobes"}, 64'(strobes), 64'd1);
        check({tag, "_strobe_cyc"}, 64'(strobe_at), 64'd32);
        check({tag, "_dat"}, got, exp);
        check({tag, "_dat_hold"}, obs_dat, exp);
    endtask

    initial begin
        int strobes;
        int bad;
        int first_at;
        int second_at;
        logic [63:0] prev;

        // Reset state
        #2;
        sel_s = 1'b0;
        check("rst_rdy_u", 64'(obs_rdy), 64'h0);
        check("rst_vld_u", 64'(obs_vld), 64'h0);
        check("rst_dat_u", obs_dat, 64'h0);
        sel_s = 1'b1;
        check("rst_rdy_s", 64'(obs_rdy), 64'h0);
        check("rst_dat_s", obs_dat, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rdy_before_edge", 64'(obs_rdy), 64'h0);
        @(posedge clk);
        #1;
        check("rdy_after_edge", 64'(obs_rdy), 64'h3);

        // Arithmetic vectors
        run_op(1'b0, 32'h00000064, 32'h00000007, 64'h0000000E_00000002, "u_100_7");
        run_op(1'b1, 32'hFFFFFF9C, 32'h00000007, 64'hFFFFFFF2_FFFFFFFE, "s_m100_7");
        run_op(1'b1, 32'h00000064, 32'hFFFFFFF9, 64'hFFFFFFF2_00000002, "s_100_m7");
        run_op(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'h00000003_FFFFFFFF, "s_m7_m2");
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, "s_min_m1");
        run_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFF_00000000, "u_max_1");
        run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "u_big_max");
        run_op(1'b1, 32'hFFFFFFFB, 32'h00000000, 64'h00000001_FFFFFFFB, "s_m5_0");
        run_op(1'b0, 32'h00000009, 32'h00000000, 64'hFFFFFFFF_00000009, "u_9_0");

        // Dividend valid alone is never accepted
        sel_s = 1'b0;
        @(negedge clk);
        dvd_dat = 32'h00000010;
        dvs_dat = 32'h00000003;
        dvd_vld = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (obs_rdy != 2'b11 || obs_vld) bad++;
        end
        dvd_vld = 1'b0;
        check("one_vld_no_accept", 64'(bad), 64'd0);

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        dvd_vld = 1'b1;
        dvs_vld = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        dvd_vld = 1'b0;
        dvs_vld = 1'b0;
        flush = 1'b0;
        check("idle_flush_rdy", 64'(obs_rdy), 64'h3);

        // Continuous valids: accepts at E0 and E34
        sel_s = 1'b0;
        @(negedge clk);
        dvd_dat = 32'h00000064;
        dvs_dat = 32'h00000007;
        dvd_vld = 1'b1;
        dvs_vld = 1'b1;
        @(posedge clk);
        #1;
        strobes = 0;
        first_at = -1;
        second_at = -1;
        for (int k = 1; k <= 67; k++) begin
            @(posedge clk);
            #1;
            if (obs_vld) begin
                strobes++;
                if (first_at < 0) first_at = k;
                else second_at = k;
                check("b2b_dat", obs_dat, 64'h0000000E_00000002);
            end
            if (k == 33) check("b2b_rdy_e33", 64'(obs_rdy), 64'h3);
            if (k == 34) check("b2b_rdy_e34", 64'(obs_rdy), 64'h0);
        end
        dvd_vld = 1'b0;
        dvs_vld = 1'b0;
        check("b2b_strobes", 64'(strobes), 64'd2);
        check("b2b_first", 64'(first_at), 64'd32);
        check("b2b_second", 64'(second_at), 64'd66);

        // Flush mid-BUSY
        sel_s = 1'b0;
        prev = obs_dat;
        @(negedge clk);
        dvd_dat = 32'hFFFFFFFF;
        dvs_dat = 32'h00000001;
        dvd_vld = 1'b1;
        dvs_vld = 1'b1;
        @(posedge clk);
        #1;
        dvd_vld = 1'b0;
        dvs_vld = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_rdy_e11", 64'(obs_rdy), 64'h3);
        strobes = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (obs_vld) strobes++;
        end
        check("flush_no_strobe", 64'(strobes), 64'd0);
        check("flush_dat_hold", obs_dat, prev);

        // Async reset mid-BUSY
        sel_s = 1'b1;
        @(negedge clk);
        dvd_dat = 32'h00000064;
        dvs_dat = 32'hFFFFFFF9;
        dvd_vld = 1'b1;
        dvs_vld = 1'b1;
        @(posedge clk);
        #1;
        dvd_vld = 1'b0;
        dvs_vld = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_dat", obs_dat, 64'h0);
        check("arst_vld", 64'(obs_vld), 64'h0);
        check("arst_rdy", 64'(obs_rdy), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        strobes = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (obs_vld) strobes++;
        end
        check("arst_no_strobe", 64'(strobes), 64'd0);
        run_op(1'b1, 32'hFFFFFF9C, 32'h00000007, 64'hFFFFFFF2_FFFFFFFE, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
